seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Receiving end of the multiplexed 4-digit display bus: active-low one-hot digit select `a[3:0]` plus a shared 4-bit nibble `d[3:0]`.
- Samples the bus, waits for each digit slot to settle, and rebuilds the 16-bit value the driver is scanning out.
  - Digit 0 = `q[3:0]`, selected by `a = 4'b1110`.
  - Digit 3 = `q[15:12]`, selected by `a = 4'b0111`.
- Used as an on-chip loopback checker for the display path and as a bus monitor in lab builds.

Parameters:
- `SETTLE`, default 2: consecutive cycles an anode pattern and nibble pair must hold unchanged before the nibble is accepted. Legal range 1..15.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `a_in` input 4: digit select from the bus, active-low, one-hot when valid.
- `d_in` input 4: nibble currently on the bus.
- `err_clr` input 1: clears the sticky error flag.
- `q_out` output 16: last complete reconstructed frame.
- `frame_valid` output 1: one-cycle pulse when `q_out` is updated.
- `digit_mask` output 4: digits captured so far in the current frame; bit i set means digit i has been captured.
- `err` output 1: sticky flag, set by an invalid anode pattern.

Behaviour:
- **Reset** (`rst_n` = 0 at an edge):
  - `q_out` = 0, shadow = 0, `digit_mask` = 0, `frame_valid` = 0, `err` = 0.
  - Sample registers are loaded with `a` = 4'b1111 and `d` = 0; run counter = 0; captured flag = 0.
  - Reset mid-frame discards any partial frame.
- **Input stage:** `a_in` and `d_in` are registered once (`s_a`, `s_d`). All decisions below use the registered values.
- **Classification of `s_a`:**
  - BLANK: 4'b1111.
  - VALID: exactly one bit is 0.
  - INVALID: any other value.
- **Run counter:**
  - Loads 1 whenever (`s_a`, `s_d`) differs from its value on the previous cycle.
  - Otherwise increments, saturating at `SETTLE`.
  - A change also clears the captured flag.
- **Capture:**
  - Condition: pattern is VALID, run reaches `SETTLE`, and the captured flag is 0.
  - Action on that edge:
    - Write `s_d` into shadow slot i, where i is the index of the 0 bit.
    - Set `digit_mask[i]`.
    - Set the captured flag, so there is at most one capture per stable run.
  - With `SETTLE` = 1, capture occurs on the first edge after the sample register changes.
- **Latency:** input change to slot write is `SETTLE` + 1 edges.
- **Frame completion:**
  - When a capture makes `digit_mask` all ones, on that same edge:
    - `q_out` is loaded with the shadow including the new nibble.
    - `frame_valid` = 1 for exactly one cycle.
    - `digit_mask` clears to 0.
  - Shadow contents are retained.
- **Duplicate digit:** a capture of an already-set digit overwrites that shadow slot; the mask is unchanged and no frame completes.
- **Scan order:** not checked. Any order that covers all four digits completes a frame.
- **BLANK:** no capture, no error; the run counter behaves normally.
- **INVALID:**
  - No capture.
  - `err` = 1 on the edge the INVALID pattern is sampled.
  - Mask and shadow are untouched.
- **`err_clr`:**
  - Clears `err` on the next edge.
  - If an INVALID pattern is sampled on the same edge, set wins and `err` stays 1.
- **Mid-run nibble change:** changes with a stable anode restart the run. Only a nibble held stable for `SETTLE` cycles is accepted.
- **Unchanging pattern:** a VALID pattern held indefinitely produces exactly one capture.

Test Plan:
1. Reset, then `SETTLE` = 2; drive `a`/`d` pairs 1110/4'h4, 1101/4'h3, 1011/4'h2, 0111/4'h1, each held 4 cycles.
   - Required: `frame_valid` pulses once with `q_out` = 16'h1234.
   - Required: `digit_mask` steps 0001, 0011, 0111, then 0000.
2. Hold `a` = 1110 for 3 cycles with `d` toggling every cycle (5, A, 5), then stable 4'hC for 2 cycles.
   - Required: only 4'hC captured; exactly one capture, at input change + 3 edges.
3. Drive `a` = 1100 for 1 cycle in the middle of a frame.
   - Required: `err` = 1, `digit_mask` unchanged.
   - Then assert `err_clr` together with `a` = 1010: `err` stays 1.
   - Then assert `err_clr` alone: `err` = 0 on the next edge.
4. Scan digits 0, 1, 0 (new value 4'h9), 2, 3.
   - Required: `q_out[3:0]` = 4'h9; exactly one `frame_valid`.
5. Assert `rst_n` = 0 after 3 digits have been captured.
   - Required: `digit_mask` = 0 and `q_out` = 0.
   - A following full scan is required for a frame.
6. Run with `SETTLE` = 1, driving a new digit every cycle (1110 through 0111, nibbles 4'hF, 4'hE, 4'hD, 4'hC).
   - Required: `q_out` = 16'hCDEF.
   - Blank (1111) gaps between digits must not produce a capture or set `err`.

Source files
------------

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_capture
//  Purpose  : Rebuilds the 16-bit value scanned out on a multiplexed 4-digit
//             display bus (active-low one-hot anode select + shared nibble).
//  Revision : 1.0  initial release
// ============================================================================
module seven_segment_capture #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  a_in,
    input  logic [3:0]  d_in,
    input  logic        err_clr,
    output logic [15:0] q_out,
    output logic        frame_valid,
    output logic [3:0]  digit_mask,
    output logic        err
);

    localparam logic [3:0] c_blank  = 4'b1111;
    localparam logic [3:0] c_all    = 4'b1111;
    localparam logic [3:0] c_settle = 4'(SETTLE);

    function automatic logic is_onehot_low(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) ||
               (a == 4'b1011) || (a == 4'b0111);
    endfunction

    logic [3:0]  s_a_q, s_a_d;
    logic [3:0]  s_d_q, s_d_d;
    logic [3:0]  p_a_q, p_a_d;
    logic [3:0]  p_d_q, p_d_d;
    logic [3:0]  run_q, run_d;
    logic        captured_q, captured_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] q_out_q, q_out_d;
    logic        frame_valid_q, frame_valid_d;
    logic        err_q, err_d;

    logic        w_change;
    logic        w_valid;
    logic        w_capture;
    logic [1:0]  w_slot;
    logic [3:0]  w_mask_new;

    always_comb begin
        w_slot = 2'd0;
        case (s_a_q)
            4'b1110: w_slot = 2'd0;
            4'b1101: w_slot = 2'd1;
            4'b1011: w_slot = 2'd2;
            4'b0111: w_slot = 2'd3;
            default: w_slot = 2'd0;
        endcase
    end

    always_comb begin
        s_a_d         = a_in;
        s_d_d         = d_in;
        p_a_d         = s_a_q;
        p_d_d         = s_d_q;
        shadow_d      = shadow_q;
        mask_d        = mask_q;
        q_out_d       = q_out_q;
        frame_valid_d = 1'b0;
        w_mask_new    = mask_q;

        w_change = (s_a_q != p_a_q) || (s_d_q != p_d_q);
        w_valid  = is_onehot_low(s_a_q);

        if (w_change) begin
            run_d = 4'd1;
        end else if (run_q >= c_settle) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 4'd1;
        end

        // A new (anode, nibble) pair re-arms the one-capture-per-run guard.
        captured_d = captured_q && !w_change;
        w_capture  = w_valid && (run_d == c_settle) && !captured_d;

        if (w_capture) begin
            captured_d                   = 1'b1;
            shadow_d[{w_slot, 2'b00} +: 4] = s_d_q;
            w_mask_new                   = mask_q | (4'b0001 << w_slot);
            if (w_mask_new == c_all) begin
                q_out_d       = shadow_d;
                frame_valid_d = 1'b1;
                mask_d        = 4'b0000;
            end else begin
                mask_d = w_mask_new;
            end
        end

        // Flagged as the bad pattern enters the sample register; set beats clear.
        err_d = (err_q && !err_clr) ||
                (!is_onehot_low(a_in) && (a_in != c_blank));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_a_q         <= c_blank;
            s_d_q         <= 4'd0;
            p_a_q         <= c_blank;
            p_d_q         <= 4'd0;
            run_q         <= 4'd0;
            captured_q    <= 1'b0;
            shadow_q      <= 16'd0;
            mask_q        <= 4'd0;
            q_out_q       <= 16'd0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            s_a_q         <= s_a_d;
            s_d_q         <= s_d_d;
            p_a_q         <= p_a_d;
            p_d_q         <= p_d_d;
            run_q         <= run_d;
            captured_q    <= captured_d;
            shadow_q      <= shadow_d;
            mask_q        <= mask_d;
            q_out_q       <= q_out_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    assign q_out       = q_out_q;
    assign frame_valid = frame_valid_q;
    assign digit_mask  = mask_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_segment_capture
//  Purpose  : Directed bench for seven_segment_capture with SETTLE=2 and SETTLE=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a_in, d_in, a1, d1;
    logic        err_clr, clr1;
    logic [15:0] q_out, q1;
    logic        frame_valid, fv1, err, e1;
    logic [3:0]  digit_mask, m1;

    int n_pass = 0;
    int n_total = 0;
    int fv_cnt = 0;
    int fv1_cnt = 0;
    int fv_base;

    always #5 clk = ~clk;

    seven_segment_capture #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .d_in(d_in), .err_clr(err_clr),
        .q_out(q_out), .frame_valid(frame_valid), .digit_mask(digit_mask), .err(err)
    );

    seven_segment_capture #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a_in(a1), .d_in(d1), .err_clr(clr1),
        .q_out(q1), .frame_valid(fv1), .digit_mask(m1), .err(e1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_valid === 1'b1) fv_cnt++;
        if (fv1 === 1'b1) fv1_cnt++;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] d, input int n);
        a_in = a;
        d_in = d;
        repeat (n) step();
    endtask

    task automatic drive1(input logic [3:0] a, input logic [3:0] d);
        a1 = a;
        d1 = d;
        step();
    endtask

    initial begin
        rst_n = 1'b0; a_in = 4'b1111; d_in = 4'h0; err_clr = 1'b0;
        a1 = 4'b1111; d1 = 4'h0; clr1 = 1'b0;
        repeat (2) step();
        check("rst_q", 32'(q_out), 32'h0);
        check("rst_mask", 32'(digit_mask), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // Basic scan 1234 with latency check on the first digit
        drive(4'b1110, 4'h4, 2);
        check("lat_not_yet", 32'(digit_mask), 32'h0);
        step();
        check("lat_capture", 32'(digit_mask), 32'h1);
        step();
        drive(4'b1101, 4'h3, 4);
        check("t1_mask2", 32'(digit_mask), 32'h3);
        drive(4'b1011, 4'h2, 4);
        check("t1_mask3", 32'(digit_mask), 32'h7);
        fv_base = fv_cnt;
        drive(4'b0111, 4'h1, 3);
        check("t1_fv_pulse", 32'(frame_valid), 32'h1);
        check("t1_q", 32'(q_out), 32'h1234);
        check("t1_mask_clr", 32'(digit_mask), 32'h0);
        step();
        check("t1_fv_drop", 32'(frame_valid), 32'h0);
        check("t1_fv_once", 32'(fv_cnt - fv_base), 32'd1);

        // Toggling nibble under a stable anode: only the settled C is taken
        drive(4'b1110, 4'h5, 1);
        drive(4'b1110, 4'hA, 1);
        drive(4'b1110, 4'h5, 1);
        drive(4'b1110, 4'hC, 2);
        check("t2_no_early", 32'(digit_mask), 32'h0);
        a_in = 4'b1111; d_in = 4'h0;
        step();
        check("t2_capture", 32'(digit_mask), 32'h1);
        step();

        // Invalid anode mid-frame, error clear interplay
        drive(4'b1101, 4'h7, 4);
        check("t3_mask_pre", 32'(digit_mask), 32'h3);
        drive(4'b1100, 4'h0, 1);
        check("t3_err_set", 32'(err), 32'h1);
        check("t3_mask_keep", 32'(digit_mask), 32'h3);
        err_clr = 1'b1;
        drive(4'b1010, 4'h0, 1);
        check("t3_set_wins", 32'(err), 32'h1);
        drive(4'b1111, 4'h0, 1);
        check("t3_err_clr", 32'(err), 32'h0);
        err_clr = 1'b0;
        step();
        check("t3_mask_after", 32'(digit_mask), 32'h3);
        fv_base = fv_cnt;
        drive(4'b1011, 4'h6, 4);
        drive(4'b0111, 4'h8, 4);
        check("t3_q", 32'(q_out), 32'h867C);
        check("t3_fv_once", 32'(fv_cnt - fv_base), 32'd1);

        // Duplicate digit overwrites its slot
        fv_base = fv_cnt;
        drive(4'b1110, 4'h1, 4);
        drive(4'b1101, 4'h2, 4);
        drive(4'b1110, 4'h9, 4);
        check("t4_dup_mask", 32'(digit_mask), 32'h3);
        drive(4'b1011, 4'h3, 4);
        drive(4'b0111, 4'h4, 4);
        check("t4_low_nib", 32'(q_out[3:0]), 32'h9);
        check("t4_q", 32'(q_out), 32'h4329);
        check("t4_fv_once", 32'(fv_cnt - fv_base), 32'd1);

        // Reset discards a partial frame
        drive(4'b1110, 4'hA, 4);
        drive(4'b1101, 4'hB, 4);
        drive(4'b1011, 4'hC, 4);
        check("t5_mask_pre", 32'(digit_mask), 32'h7);
        rst_n = 1'b0;
        drive(4'b1111, 4'h0, 1);
        check("t5_mask_rst", 32'(digit_mask), 32'h0);
        check("t5_q_rst", 32'(q_out), 32'h0);
        rst_n = 1'b1;
        repeat (2) step();
        fv_base = fv_cnt;
        drive(4'b0111, 4'hD, 4);
        check("t5_partial", 32'(digit_mask), 32'h8);
        check("t5_no_frame", 32'(fv_cnt - fv_base), 32'd0);
        drive(4'b1110, 4'h1, 4);
        drive(4'b1101, 4'h2, 4);
        drive(4'b1011, 4'h3, 4);
        check("t5_q", 32'(q_out), 32'hD321);

        // SETTLE=1: one digit per cycle, then with blank gaps
        fv_base = fv1_cnt;
        drive1(4'b1110, 4'hF);
        drive1(4'b1101, 4'hE);
        check("t6_first", 32'(m1), 32'h1);
        drive1(4'b1011, 4'hD);
        drive1(4'b0111, 4'hC);
        drive1(4'b1111, 4'h0);
        check("t6_fv", 32'(fv1), 32'h1);
        check("t6_q", 32'(q1), 32'hCDEF);
        step();
        drive1(4'b1110, 4'h1);
        drive1(4'b1111, 4'h0);
        check("t6_gap1", 32'(m1), 32'h1);
        drive1(4'b1101, 4'h2);
        drive1(4'b1111, 4'h0);
        check("t6_gap2", 32'(m1), 32'h3);
        drive1(4'b1011, 4'h3);
        drive1(4'b1111, 4'h0);
        check("t6_gap3", 32'(m1), 32'h7);
        drive1(4'b0111, 4'h4);
        drive1(4'b1111, 4'h0);
        step();
        check("t6_gap_q", 32'(q1), 32'h4321);
        check("t6_gap_err", 32'(e1), 32'h0);
        check("t6_frames", 32'(fv1_cnt - fv_base), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
